// File: rtl/nubus_drv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : nubus_drv_seq
//  Purpose  : NuBus driver-enable sequencer. Arbitrates between master
//             (START) and slave (ACK/TM) drive, inserts dead cycles on every
//             direction change, bounds slave drive time and runs the RQST
//             open-collector request handshake.
//  Options  : NUBUS_DRV_SEQ_TM2_EN - when defined, TM2 is sequenced with
//             ACK/TM0/TM1 if NUM_TM = 3; otherwise tm2_oe_n is tied high.
//  Revision : 1.0 - initial release
// ============================================================================
module nubus_drv_seq #(
    parameter int TURN_CYCLES   = 1,
    parameter int DRIVE_TIMEOUT = 255,
    parameter int NUM_TM        = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic nubus_oe,
    input  logic master_req,
    input  logic slave_req,
    input  logic rqst_req,
    input  logic rqst_n_5v,
    output logic start_oe_n,
    output logic ack_oe_n,
    output logic tmx_oe_n,
    output logic tm2_oe_n,
    output logic nubus_master_dir,
    output logic tmoen,
    output logic rqst_o_n,
    output logic busy,
    output logic timeout_err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_master = 2'd1;
    localparam logic [1:0] c_st_slave  = 2'd2;
    localparam logic [1:0] c_st_turn   = 2'd3;

    // Terminal counts: the counters start at 0 on entry, so the last cycle
    // of a phase is reached when the count equals the length minus one.
    localparam logic [2:0]  c_turn_last = 3'(TURN_CYCLES - 1);
    localparam logic [15:0] c_slv_last  = 16'(DRIVE_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_timeout;
    logic [2:0]  r_turn_cnt;
    logic [15:0] r_slv_cnt;
    logic        r_lockout;

    logic        r_start_oe_n;
    logic        r_ack_oe_n;
    logic        r_tmx_oe_n;
    logic        r_master_dir;
    logic        r_tmoen;
    logic        r_busy;
    logic        r_timeout_err;
    logic        r_rqst_o_n;

    // Next-state decision; slave has priority over master, TURN ignores requests.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!nubus_oe) begin
                    if (slave_req) begin
                        // A pending slave request blocks master even while locked out.
                        if (!r_lockout) begin
                            w_next_state = c_st_slave;
                        end
                    end else if (master_req) begin
                        w_next_state = c_st_master;
                    end
                end
            end
            c_st_master: begin
                if (nubus_oe || !master_req) begin
                    w_next_state = c_st_turn;
                end
            end
            c_st_slave: begin
                if (nubus_oe || !slave_req) begin
                    w_next_state = c_st_turn;
                end else if (r_slv_cnt == c_slv_last) begin
                    w_next_state = c_st_turn;
                    w_timeout    = 1'b1;
                end
            end
            c_st_turn: begin
                if (r_turn_cnt == c_turn_last) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // State register and phase counters; counters restart whenever a phase is entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_turn_cnt <= 3'd0;
            r_slv_cnt  <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_st_turn && w_next_state == c_st_turn) begin
                r_turn_cnt <= r_turn_cnt + 3'd1;
            end else begin
                r_turn_cnt <= 3'd0;
            end
            if (r_state == c_st_slave && w_next_state == c_st_slave) begin
                r_slv_cnt <= r_slv_cnt + 16'd1;
            end else begin
                r_slv_cnt <= 16'd0;
            end
        end
    end

    // Slave lockout: armed by a forced release, cleared once slave_req is seen low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lockout <= 1'b0;
        end else if (w_timeout) begin
            r_lockout <= 1'b1;
        end else if (!slave_req) begin
            r_lockout <= 1'b0;
        end
    end

    // Registered driver controls decoded from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_oe_n  <= 1'b1;
            r_ack_oe_n    <= 1'b1;
            r_tmx_oe_n    <= 1'b1;
            r_master_dir  <= 1'b0;
            r_tmoen       <= 1'b1;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start_oe_n  <= (w_next_state != c_st_master);
            r_ack_oe_n    <= (w_next_state != c_st_slave);
            r_tmx_oe_n    <= (w_next_state != c_st_slave);
            r_master_dir  <= (w_next_state == c_st_master);
            r_tmoen       <= (w_next_state != c_st_slave);
            r_busy        <= (w_next_state != c_st_idle);
            r_timeout_err <= w_timeout;
        end
    end

    // RQST: assert only onto an idle bus line, then hold until the request drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rqst_o_n <= 1'b1;
        end else if (!rqst_req) begin
            r_rqst_o_n <= 1'b1;
        end else if (r_rqst_o_n && rqst_n_5v) begin
            r_rqst_o_n <= 1'b0;
        end
    end

`ifdef NUBUS_DRV_SEQ_TM2_EN
    localparam logic c_tm2_used = (NUM_TM == 3);

    logic r_tm2_oe_n;

    // TM2 follows the other slave drivers only when a third TM line exists.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tm2_oe_n <= 1'b1;
        end else begin
            r_tm2_oe_n <= !(c_tm2_used && (w_next_state == c_st_slave));
        end
    end

    assign tm2_oe_n = r_tm2_oe_n | nubus_oe;
`else
    assign tm2_oe_n = 1'b1;
`endif

    // nubus_oe is the only combinational path: it kills every 5 V driver at once.
    assign start_oe_n       = r_start_oe_n | nubus_oe;
    assign ack_oe_n         = r_ack_oe_n   | nubus_oe;
    assign tmx_oe_n         = r_tmx_oe_n   | nubus_oe;
    assign rqst_o_n         = r_rqst_o_n   | nubus_oe;
    assign nubus_master_dir = r_master_dir;
    assign tmoen            = r_tmoen;
    assign busy             = r_busy;
    assign timeout_err      = r_timeout_err;

endmodule
`default_nettype wire
